// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS datapath constants, funct codes and divider state type
package mips_pkg;

   localparam int DATA_WIDTH = 32;

   // R-type funct codes handled by the ALU
   localparam logic [5:0] FUNCT_ADD   = 6'b100000;
   localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
   localparam logic [5:0] FUNCT_SUB   = 6'b100010;
   localparam logic [5:0] FUNCT_SUBU  = 6'b100011;
   localparam logic [5:0] FUNCT_AND   = 6'b100100;
   localparam logic [5:0] FUNCT_OR    = 6'b100101;
   localparam logic [5:0] FUNCT_SLT   = 6'b101010;
   localparam logic [5:0] FUNCT_MULT  = 6'b011000;
   localparam logic [5:0] FUNCT_MULTU = 6'b011001;

   // R-type funct codes handled by the iterative divider
   localparam logic [5:0] FUNCT_DIV   = 6'b011010;
   localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } div_state_e;

endpackage

// File: rtl/mips_divider_if.sv
// rtl/mips_divider_if.sv - request/result bundle between pipeline control and the divider
interface mips_divider_if #(
   parameter int DATA_WIDTH = 32
) ();

   logic                  start;
   logic                  is_signed;
   logic [DATA_WIDTH-1:0] src_a;
   logic [DATA_WIDTH-1:0] src_b;
   logic                  busy;
   logic                  done;
   logic [DATA_WIDTH-1:0] result_hi;
   logic [DATA_WIDTH-1:0] result_lo;
   logic                  div_by_zero;

   modport master (
      output start, is_signed, src_a, src_b,
      input  busy, done, result_hi, result_lo, div_by_zero
   );

   modport slave (
      input  start, is_signed, src_a, src_b,
      output busy, done, result_hi, result_lo, div_by_zero
   );

endinterface

// File: rtl/mips_divider_div_step.sv
// rtl/mips_divider_div_step.sv - one combinational restoring-division iteration
module div_step #(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH:0]   rem_i,
   input  logic [DATA_WIDTH-1:0] quo_i,
   input  logic [DATA_WIDTH-1:0] divisor_i,
   output logic [DATA_WIDTH:0]   rem_o,
   output logic [DATA_WIDTH-1:0] quo_o
);

   logic [DATA_WIDTH+1:0] rem_sh;
   logic [DATA_WIDTH+1:0] trial;

   // shift {rem, quo} left, try subtracting the divisor, restore on borrow
   always_comb begin
      rem_sh = {rem_i, quo_i[DATA_WIDTH-1]};
      trial  = rem_sh - {2'b00, divisor_i};
      if (trial[DATA_WIDTH+1]) begin
         rem_o = rem_sh[DATA_WIDTH:0];
         quo_o = {quo_i[DATA_WIDTH-2:0], 1'b0};
      end else begin
         rem_o = trial[DATA_WIDTH:0];
         quo_o = {quo_i[DATA_WIDTH-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/mips_divider.sv
// rtl/mips_divider.sv - iterative DIV/DIVU unit returning quotient on LO and remainder on HI
module mips_divider #(
   parameter int DATA_WIDTH  = mips_pkg::DATA_WIDTH,
   parameter int COUNT_WIDTH = 6
) (
   input  logic           clk,
   input  logic           rst_n,
   mips_divider_if.slave  bus
);

   import mips_pkg::*;

   localparam int W = DATA_WIDTH;

   div_state_e             state_q, state_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic [W:0]             rem_q, rem_d;
   logic [W-1:0]           quo_q, quo_d;
   logic [W-1:0]           dvs_q, dvs_d;
   logic                   q_neg_q, q_neg_d;
   logic                   r_neg_q, r_neg_d;
   logic                   zero_q, zero_d;
   logic [W-1:0]           hi_q, hi_d;
   logic [W-1:0]           lo_q, lo_d;
   logic                   dbz_q, dbz_d;
   logic                   done_q, done_d;

   logic [W:0]             step_rem;
   logic [W-1:0]           step_quo;
   logic                   a_neg, b_neg;
   logic [W-1:0]           a_mag, b_mag;

   div_step #(.DATA_WIDTH(W)) u_step (
      .rem_i     (rem_q),
      .quo_i     (quo_q),
      .divisor_i (dvs_q),
      .rem_o     (step_rem),
      .quo_o     (step_quo)
   );

   // operand magnitudes and signs for DIV; DIVU passes operands straight through
   always_comb begin
      a_neg = bus.is_signed & bus.src_a[W-1];
      b_neg = bus.is_signed & bus.src_b[W-1];
      a_mag = a_neg ? -bus.src_a : bus.src_a;
      b_mag = b_neg ? -bus.src_b : bus.src_b;
   end

   // next-state and datapath updates for IDLE -> CALC -> FIX
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      q_neg_d = q_neg_q;
      r_neg_d = r_neg_q;
      zero_d  = zero_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dbz_d   = dbz_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               q_neg_d = a_neg ^ b_neg;
               r_neg_d = a_neg;
               dvs_d   = b_mag;
               rem_d   = '0;
               if (bus.src_b == '0) begin
                  // raw dividend parked in quo for HI; one FIX dwell cycle keeps latency at two edges
                  zero_d  = 1'b1;
                  quo_d   = bus.src_a;
                  count_d = COUNT_WIDTH'(1);
                  state_d = S_FIX;
               end else begin
                  zero_d  = 1'b0;
                  quo_d   = a_mag;
                  count_d = COUNT_WIDTH'(W);
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            rem_d   = step_rem;
            quo_d   = step_quo;
            count_d = count_q - COUNT_WIDTH'(1);
            if (count_q == COUNT_WIDTH'(1)) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            if (count_q != '0) begin
               count_d = count_q - COUNT_WIDTH'(1);
            end else begin
               if (zero_q) begin
                  lo_d  = '1;
                  hi_d  = quo_q;
                  dbz_d = 1'b1;
               end else begin
                  lo_d  = q_neg_q ? -quo_q : quo_q;
                  hi_d  = r_neg_q ? -rem_q[W-1:0] : rem_q[W-1:0];
                  dbz_d = 1'b0;
               end
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // state and datapath registers, asynchronously cleared
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         count_q <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
         zero_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         dbz_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         q_neg_q <= q_neg_d;
         r_neg_q <= r_neg_d;
         zero_q  <= zero_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         dbz_q   <= dbz_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy        = (state_q != S_IDLE);
   assign bus.done        = done_q;
   assign bus.result_hi   = hi_q;
   assign bus.result_lo   = lo_q;
   assign bus.div_by_zero = dbz_q;

endmodule
